// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand stage.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ZERO     = 0;

    // Encoding 2'd3 is reserved and decodes like A_ZERO.
    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// ID/EX input slot, forwarding ports and ALU output slot of the operand stage.
interface alu_operand_stage_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [RADDR-1:0]        rs1_addr;
    logic [RADDR-1:0]        rs2_addr;
    logic [XLEN-1:0]         rd1;
    logic [XLEN-1:0]         rd2;
    logic [XLEN-1:0]         imm;
    logic [XLEN-1:0]         pc;
    logic [1:0]              a_sel;
    logic                    alu_src;
    logic                    exm_wen;
    logic                    exm_is_load;
    logic [RADDR-1:0]        exm_rd;
    logic [XLEN-1:0]         exm_data;
    logic                    wb_wen;
    logic [RADDR-1:0]        wb_rd;
    logic [XLEN-1:0]         wb_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [XLEN-1:0]  out_a;
    logic signed [XLEN-1:0]  out_b;
    logic [XLEN-1:0]         out_sd;
    logic [31:0]             stall_cnt;

    modport master (
        output in_valid, rs1_addr, rs2_addr, rd1, rd2, imm, pc, a_sel, alu_src,
               exm_wen, exm_is_load, exm_rd, exm_data, wb_wen, wb_rd, wb_data,
               flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_sd, stall_cnt
    );

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, rd1, rd2, imm, pc, a_sel, alu_src,
               exm_wen, exm_is_load, exm_rd, exm_data, wb_wen, wb_rd, wb_data,
               flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_sd, stall_cnt
    );

endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Resolves one source operand: x0, EX/MEM bypass, MEM/WB bypass or register file.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] rs_addr_i,
    input  logic [XLEN-1:0]  rf_data_i,
    input  logic             exm_wen_i,
    input  logic [RADDR-1:0] exm_rd_i,
    input  logic [XLEN-1:0]  exm_data_i,
    input  logic             wb_wen_i,
    input  logic [RADDR-1:0] wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    output logic [XLEN-1:0]  fwd_data_o
);

    // Younger EX/MEM result takes priority over MEM/WB.
    always_comb begin
        fwd_data_o = rf_data_i;
        if (rs_addr_i == RADDR'(REG_ZERO)) begin
            fwd_data_o = '0;
        end else if (exm_wen_i && (exm_rd_i == rs_addr_i)) begin
            fwd_data_o = exm_data_i;
        end else if (wb_wen_i && (wb_rd_i == rs_addr_i)) begin
            fwd_data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// EX-entry stage: operand select with forwarding, load-use hazard detection,
// registered valid/ready output slot and a saturating stall-cycle counter.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int RADDR = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_operand_stage_if.slave bus
);

    logic [XLEN-1:0]        rs1_val;
    logic [XLEN-1:0]        rs2_val;
    logic [XLEN-1:0]        a_val;
    logic [XLEN-1:0]        b_val;
    logic                   rs1_used;
    logic                   hazard;
    logic                   in_ready;
    logic                   accept;

    logic                   out_valid_q, out_valid_d;
    logic signed [XLEN-1:0] out_a_q, out_a_d;
    logic signed [XLEN-1:0] out_b_q, out_b_d;
    logic [XLEN-1:0]        out_sd_q, out_sd_d;
    logic [31:0]            stall_cnt_q, stall_cnt_d;

    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs1 (
        .rs_addr_i  (bus.rs1_addr),
        .rf_data_i  (bus.rd1),
        .exm_wen_i  (bus.exm_wen),
        .exm_rd_i   (bus.exm_rd),
        .exm_data_i (bus.exm_data),
        .wb_wen_i   (bus.wb_wen),
        .wb_rd_i    (bus.wb_rd),
        .wb_data_i  (bus.wb_data),
        .fwd_data_o (rs1_val)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs2 (
        .rs_addr_i  (bus.rs2_addr),
        .rf_data_i  (bus.rd2),
        .exm_wen_i  (bus.exm_wen),
        .exm_rd_i   (bus.exm_rd),
        .exm_data_i (bus.exm_data),
        .wb_wen_i   (bus.wb_wen),
        .wb_rd_i    (bus.wb_rd),
        .wb_data_i  (bus.wb_data),
        .fwd_data_o (rs2_val)
    );

    always_comb begin
        a_val = '0;
        case (bus.a_sel)
            A_RS1:   a_val = rs1_val;
            A_PC:    a_val = bus.pc;
            default: a_val = '0;
        endcase
    end

    assign b_val = bus.alu_src ? bus.imm : rs2_val;

    // rs2 always counts as a consumer because it also supplies store data.
    assign rs1_used = (bus.a_sel == A_RS1);
    assign hazard   = bus.in_valid && bus.exm_wen && bus.exm_is_load
                   && (bus.exm_rd != RADDR'(REG_ZERO))
                   && ((rs1_used && (bus.exm_rd == bus.rs1_addr))
                       || (bus.exm_rd == bus.rs2_addr));

    assign in_ready = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        out_a_d  = out_a_q;
        out_b_d  = out_b_q;
        out_sd_d = out_sd_q;
        if (accept) begin
            out_a_d  = a_val;
            out_b_d  = b_val;
            out_sd_d = rs2_val;
        end
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = out_valid_q && !bus.out_ready;
        end
        stall_cnt_d = (hazard && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_sd_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_sd_q    <= out_sd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_sd    = out_sd_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding, hazards, back-pressure, flush, reset.
module tb_alu_operand_stage;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    int   n_fail;

    alu_operand_stage_if #(.XLEN(32), .RADDR(5)) bus ();

    alu_operand_stage #(.XLEN(32), .RADDR(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
        $display("check %-14s obs=0x%08h exp=0x%08h", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        bus.rd1         = '0;
        bus.rd2         = '0;
        bus.imm         = '0;
        bus.pc          = '0;
        bus.a_sel       = 2'd0;
        bus.alu_src     = 1'b0;
        bus.exm_wen     = 1'b0;
        bus.exm_is_load = 1'b0;
        bus.exm_rd      = '0;
        bus.exm_data    = '0;
        bus.wb_wen      = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;
        #2;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_a", bus.out_a, 32'd0);
        chk("rst_sd", bus.out_sd, 32'd0);
        chk("rst_stall", bus.stall_cnt, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain register-file operands
        bus.rs1_addr = 5'd3; bus.rd1 = 32'd5;
        bus.rs2_addr = 5'd4; bus.rd2 = 32'd7;
        bus.in_valid = 1'b1;
        #1;
        chk("nofwd_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("nofwd_valid", 32'(bus.out_valid), 32'd1);
        chk("nofwd_a", bus.out_a, 32'd5);
        chk("nofwd_b", bus.out_b, 32'd7);
        chk("nofwd_sd", bus.out_sd, 32'd7);

        // Both stages match rs1: EX/MEM wins
        bus.exm_wen = 1'b1; bus.exm_rd = 5'd3; bus.exm_data = 32'h11;
        bus.wb_wen  = 1'b1; bus.wb_rd  = 5'd3; bus.wb_data  = 32'h22;
        step();
        chk("fwd_exm_a", bus.out_a, 32'h11);
        chk("fwd_exm_b", bus.out_b, 32'd7);
        bus.exm_rd = 5'd9;
        step();
        chk("fwd_wb_a", bus.out_a, 32'h22);
        bus.rs1_addr = 5'd0; bus.rd1 = 32'h55; bus.exm_rd = 5'd0; bus.wb_rd = 5'd0;
        step();
        chk("fwd_x0_a", bus.out_a, 32'd0);

        // Load-use on rs2
        bus.wb_wen = 1'b0;
        bus.rs1_addr = 5'd3; bus.rd1 = 32'd5;
        bus.exm_wen = 1'b1; bus.exm_is_load = 1'b1; bus.exm_rd = 5'd4; bus.exm_data = 32'hDEAD;
        #1;
        chk("lu_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("lu_stall", bus.stall_cnt, 32'd1);
        chk("lu_drained", 32'(bus.out_valid), 32'd0);
        chk("lu_held_a", bus.out_a, 32'd0);
        bus.exm_wen = 1'b0; bus.exm_is_load = 1'b0; bus.exm_rd = 5'd0;
        bus.wb_wen = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h99;
        #1;
        chk("lu_ready2", 32'(bus.in_ready), 32'd1);
        step();
        chk("lu_sd", bus.out_sd, 32'h99);
        chk("lu_b", bus.out_b, 32'h99);
        chk("lu_a", bus.out_a, 32'd5);
        chk("lu_stall_hold", bus.stall_cnt, 32'd1);

        // Hazard source-usage corner cases (combinational only)
        bus.wb_wen = 1'b0;
        bus.exm_wen = 1'b1; bus.exm_is_load = 1'b1; bus.exm_rd = 5'd3;
        bus.a_sel = 2'd1;
        #1;
        chk("hz_rs1_unused", 32'(bus.in_ready), 32'd1);
        bus.a_sel = 2'd0;
        #1;
        chk("hz_rs1_used", 32'(bus.in_ready), 32'd0);
        bus.exm_rd = 5'd0; bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
        #1;
        chk("hz_x0", 32'(bus.in_ready), 32'd1);
        bus.exm_wen = 1'b0; bus.exm_is_load = 1'b0;
        bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd4;

        // PC and immediate select; store data stays RS2
        bus.a_sel = 2'd1; bus.pc = 32'h100; bus.alu_src = 1'b1; bus.imm = 32'hFFFF_FFFC;
        step();
        chk("pc_a", bus.out_a, 32'h100);
        chk("imm_b", bus.out_b, 32'hFFFF_FFFC);
        chk("imm_sd", bus.out_sd, 32'd7);
        bus.a_sel = 2'd3; bus.imm = 32'h10;
        step();
        chk("asel3_a", bus.out_a, 32'd0);
        chk("asel3_b", bus.out_b, 32'h10);

        // Back-pressure for three cycles
        bus.a_sel = 2'd0; bus.rd1 = 32'h77; bus.alu_src = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(bus.in_ready), 32'd0);
            step();
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_a", bus.out_a, 32'd0);
            chk("bp_b", bus.out_b, 32'h10);
        end

        // Flush with an incoming instruction and a live hazard
        bus.flush = 1'b1;
        bus.exm_wen = 1'b1; bus.exm_is_load = 1'b1; bus.exm_rd = 5'd3;
        step();
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_a", bus.out_a, 32'd0);
        chk("fl_stall", bus.stall_cnt, 32'd2);
        bus.flush = 1'b0; bus.exm_wen = 1'b0; bus.exm_is_load = 1'b0; bus.exm_rd = 5'd0;
        bus.out_ready = 1'b1;
        step();
        chk("post_fl_valid", 32'(bus.out_valid), 32'd1);
        chk("post_fl_a", bus.out_a, 32'h77);

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_stall", bus.stall_cnt, 32'd0);
        chk("arst_a", bus.out_a, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_empty", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised successor to the single-cycle ALU B-operand select, used as the EX-entry stage of the pipelined core. It selects the A and B ALU operands, forwards results from the EX/MEM and MEM/WB stages, and detects load-use hazards. The selected operands are registered into a valid/ready output slot that feeds the ALU. The stage also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- XLEN, 32, datapath width
- RADDR, 5, register-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX slot holds an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- rs1_addr, rs2_addr  in  RADDR  source register indices
- rd1, rd2  in  XLEN  register-file read data
- imm  in  XLEN  sign-extended immediate
- pc  in  XLEN  instruction address
- a_sel  in  2  A source: 0 = RS1, 1 = PC, 2 = zero, 3 = reserved (treated as zero)
- alu_src  in  1  B source: 0 = RS2, 1 = imm
- exm_wen, exm_is_load  in  1  EX/MEM instruction writes rd / is a load
- exm_rd  in  RADDR  EX/MEM destination register
- exm_data  in  XLEN  EX/MEM ALU result
- wb_wen  in  1  MEM/WB writes rd
- wb_rd  in  RADDR  MEM/WB destination register
- wb_data  in  XLEN  MEM/WB write-back data
- flush  in  1  kill the in-flight and incoming instruction
- out_valid  out  1  output slot full
- out_ready  in  1  ALU consumes the slot
- out_a, out_b  out  XLEN signed  ALU operands
- out_sd  out  XLEN  forwarded RS2 value, used as store data
- stall_cnt  out  32  saturating count of hazard-stall cycles

## Operation
- Forwarding applies per source (rs1, rs2):
  - Index 0 always yields 0 and is never forwarded.
  - Otherwise, use exm_data if exm_wen and exm_rd match; else wb_data if wb_wen and wb_rd match; else rd1/rd2.
  - EX/MEM wins when both stages match.
- A operand: forwarded RS1, pc, or 0, per a_sel.
- B operand: imm if alu_src is 1, else forwarded RS2.
- out_sd is always forwarded RS2, independent of alu_src.
- Hazard: asserted when in_valid, exm_wen, exm_is_load, exm_rd ≠ 0, and exm_rd equals a source that is actually used.
  - rs1 is used only when a_sel = 0.
  - rs2 is used when alu_src = 0, or always if store data is needed. For simplicity, rs2 is always treated as used.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready. On accept, out_a, out_b, and out_sd are loaded and out_valid is set to 1.
- Drain occurs when out_valid && out_ready with no accept. On drain, out_valid is cleared; data is held.
- flush: out_valid clears on the next edge. No accept happens in the flush cycle.
- stall_cnt increments on every cycle in which hazard is true. It saturates at 0xFFFF_FFFF and is cleared only by reset.

## Timing
- Reset values: out_valid = 0, out_a = out_b = out_sd = 0, stall_cnt = 0. in_ready is combinational and equals 1 when flush = 0 and hazard = 0.
- Latency is 1 cycle. Operands captured at the accept edge appear at out_* in the following cycle.
- Throughput is 1 instruction per cycle when out_ready is held high.
- Back-pressure: while out_valid && !out_ready, the outputs stay stable and in_ready is 0.
- A load-use hazard lasts exactly as long as the matching load sits in EX/MEM, typically 1 cycle. The upstream must hold its inputs stable while in_ready = 0.
- Simultaneous flush and out_ready: the slot empties, nothing is loaded, and stall_cnt still counts if hazard is true.
- Reset asserted mid-stream: all registers clear immediately and asynchronously. The output slot is empty after deassertion.

## Structure
- Package alu_pkg holds:
  - XLEN_DEFAULT = 32
  - enum a_sel_t with values A_RS1, A_PC, A_ZERO
  - the helper constant REG_ZERO = 0
- Sub-module fwd_mux (parameters XLEN, RADDR) resolves one source operand from the register-file value and the two forwarding ports. It is instantiated twice, once for rs1 and once for rs2.
- Top level contains the hazard logic, the output register, the handshake, and the stall counter.

## Test plan
- No forwarding: rs1 = 3, rd1 = 5, rs2 = 4, rd2 = 7, alu_src = 0, a_sel = 0 -> next cycle out_a = 5, out_b = 7, out_valid = 1.
- Dual forwarding: exm_rd = 3 with exm_data = 0x11, and wb_rd = 3 with wb_data = 0x22 -> out_a = 0x11. Remove the EX/MEM match -> out_a = 0x22. With rs1 = 0 and all ports matching x0 -> out_a = 0.
- Load-use: exm_is_load = 1, exm_rd = 4, rs2 = 4 for one cycle -> in_ready = 0 for that cycle and stall_cnt = 1. Next cycle, wb_rd = 4 with wb_data = 0x99 -> accepted, out_sd = 0x99.
- Immediate and PC select: a_sel = 1, pc = 0x100, alu_src = 1, imm = -4 -> out_a = 0x100, out_b = 0xFFFF_FFFC.
- Back-pressure and flush: hold out_ready = 0 for 3 cycles -> outputs stable and in_ready = 0. Then assert flush together with in_valid -> out_valid = 0 next cycle and nothing captured.
- Async reset: deassert rst_n mid-stream between clock edges -> out_valid and stall_cnt read 0 immediately.
